// File: rtl/matrix_scan_ctrl.sv
// Row-scan controller for a 16x16 LED dot matrix.
// Walks a 4-bit row index through the pattern ROMs and latches the returned
// column word. Each row slot starts with a blanking gap to stop ghosting. The
// displayed pattern changes only at frame boundaries, either from a manual
// select or by auto-rotation every FRAMES_PER_PAT frames.

module matrix_scan_ctrl #(
    parameter int DIV            = 1000,
    parameter int BLANK          = 4,
    parameter int NUM_PAT        = 4,
    parameter int FRAMES_PER_PAT = 60
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        auto_mode,
    input  logic [1:0]  pat_sel_in,
    input  logic [15:0] pat_col,
    output logic [3:0]  row_bin,
    output logic [1:0]  pat_idx,
    output logic [15:0] row,
    output logic [15:0] col,
    output logic        frame_done
);

    localparam int DIV_W = $clog2(DIV);
    localparam int FC_W  = $clog2(FRAMES_PER_PAT + 1);

    localparam logic [DIV_W-1:0] BLANK_LAST = DIV_W'(BLANK - 1);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);
    localparam logic [FC_W-1:0]  FC_LAST    = FC_W'(FRAMES_PER_PAT - 1);
    localparam logic [FC_W-1:0]  FC_ONE     = FC_W'(1);
    localparam logic [1:0]       PAT_LAST   = 2'(NUM_PAT - 1);
    localparam logic [2:0]       PAT_COUNT  = 3'(NUM_PAT);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_SHOW  = 2'd2;

    logic [1:0]       state;
    logic [DIV_W-1:0] div_cnt;
    logic [FC_W-1:0]  frame_cnt;
    logic             frame_edge;

    // The SHOW-exit edge of row 15 is the only point a pattern may change.
    assign frame_edge = en && (state == ST_SHOW) && (div_cnt == DIV_LAST) &&
                        (row_bin == 4'hF);

    // Scan sequencer: blank gap, then latch the ROM word and light the row.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            div_cnt    <= '0;
            row_bin    <= '0;
            row        <= '0;
            col        <= '0;
            frame_done <= 1'b0;
        end else if (!en) begin
            state      <= ST_IDLE;
            div_cnt    <= '0;
            row_bin    <= '0;
            row        <= '0;
            col        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    state   <= ST_BLANK;
                    div_cnt <= '0;
                    row_bin <= '0;
                    row     <= '0;
                    col     <= '0;
                end
                ST_BLANK: begin
                    div_cnt <= div_cnt + DIV_ONE;
                    // The ROM has had BLANK cycles to settle on row_bin/pat_idx.
                    if (div_cnt == BLANK_LAST) begin
                        col   <= pat_col;
                        row   <= 16'b1 << row_bin;
                        state <= ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt    <= '0;
                        row        <= '0;
                        col        <= '0;
                        row_bin    <= row_bin + 4'd1;
                        state      <= ST_BLANK;
                        frame_done <= (row_bin == 4'hF);
                    end else begin
                        div_cnt <= div_cnt + DIV_ONE;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    div_cnt <= '0;
                    row_bin <= '0;
                    row     <= '0;
                    col     <= '0;
                end
            endcase
        end
    end

    // Pattern selection, evaluated only at frame boundaries.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pat_idx   <= '0;
            frame_cnt <= '0;
        end else if (!en) begin
            frame_cnt <= '0;
        end else if (frame_edge) begin
            if (auto_mode) begin
                if (frame_cnt == FC_LAST) begin
                    frame_cnt <= '0;
                    pat_idx   <= (pat_idx == PAT_LAST) ? 2'd0 : pat_idx + 2'd1;
                end else begin
                    frame_cnt <= frame_cnt + FC_ONE;
                end
            end else begin
                frame_cnt <= '0;
                // Out-of-range selections are ignored so an unused ROM slot is never shown.
                if ({1'b0, pat_sel_in} < PAT_COUNT) begin
                    pat_idx <= pat_sel_in;
                end
            end
        end
    end

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Testbench for matrix_scan_ctrl: two instances (NUM_PAT=4 and NUM_PAT=3) share
// stimulus; a phase-based model predicts every output each cycle, and directed
// literal checks pin the model's behaviour.

module tb_matrix_scan_ctrl;

    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FPP   = 2;
    localparam int SLOTS = 16 * DIV;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        auto_mode;
    logic [1:0]  pat_sel_in;
    logic [15:0] col_xor;

    logic [15:0] pat_col [2];
    logic [3:0]  rb      [2];
    logic [1:0]  pi      [2];
    logic [15:0] row_o   [2];
    logic [15:0] col_o   [2];
    logic        fd      [2];

    int n_vec;
    int n_err;

    // Pattern ROM contents; pattern 0 row 0 is 16'h0FF0.
    function automatic logic [15:0] rom(input logic [1:0] p, input logic [3:0] r);
        return 16'h0FF0 ^ (16'(r) * 16'h1001) ^ (16'(p) * 16'h0110);
    endfunction

    assign pat_col[0] = rom(pi[0], rb[0]) ^ col_xor;
    assign pat_col[1] = rom(pi[1], rb[1]) ^ col_xor;

    matrix_scan_ctrl #(.DIV(DIV), .BLANK(BLANK), .NUM_PAT(4), .FRAMES_PER_PAT(FPP)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .auto_mode(auto_mode),
        .pat_sel_in(pat_sel_in), .pat_col(pat_col[0]), .row_bin(rb[0]),
        .pat_idx(pi[0]), .row(row_o[0]), .col(col_o[0]), .frame_done(fd[0])
    );

    matrix_scan_ctrl #(.DIV(DIV), .BLANK(BLANK), .NUM_PAT(3), .FRAMES_PER_PAT(FPP)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .auto_mode(auto_mode),
        .pat_sel_in(pat_sel_in), .pat_col(pat_col[1]), .row_bin(rb[1]),
        .pat_idx(pi[1]), .row(row_o[1]), .col(col_o[1]), .frame_done(fd[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int inst, input logic [15:0] act,
                       input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, inst, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: wait budget expired", name);
    endtask

    // Model state: scan phase counted from the first BLANK cycle of row 0.
    bit          m_act   [2];
    int          m_phase [2];
    int          m_pat   [2];
    int          m_fcnt  [2];
    logic [15:0] m_col   [2];
    bit          m_fd    [2];

    function automatic int num_pat(input int i);
        return (i == 0) ? 4 : 3;
    endfunction

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 0; m_phase[i] = 0; m_pat[i] = 0;
            m_fcnt[i] = 0; m_col[i] = '0; m_fd[i] = 0;
        end
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!rst_n) begin
                    m_act[i] = 0; m_phase[i] = 0; m_pat[i] = 0;
                    m_fcnt[i] = 0; m_fd[i] = 0;
                end else if (!en) begin
                    m_act[i] = 0; m_phase[i] = 0; m_fcnt[i] = 0; m_fd[i] = 0;
                end else if (!m_act[i]) begin
                    m_act[i] = 1; m_phase[i] = 0; m_fd[i] = 0;
                end else begin
                    m_fd[i] = 0;
                    if (m_phase[i] % DIV == BLANK - 1)
                        m_col[i] = rom(2'(m_pat[i]), 4'((m_phase[i] / DIV) % 16)) ^ col_xor;
                    if (m_phase[i] == SLOTS - 1) begin
                        m_fd[i] = 1;
                        if (auto_mode) begin
                            if (m_fcnt[i] == FPP - 1) begin
                                m_fcnt[i] = 0;
                                m_pat[i]  = (m_pat[i] + 1) % num_pat(i);
                            end else begin
                                m_fcnt[i] = m_fcnt[i] + 1;
                            end
                        end else begin
                            m_fcnt[i] = 0;
                            if (int'(pat_sel_in) < num_pat(i)) m_pat[i] = int'(pat_sel_in);
                        end
                    end
                    m_phase[i] = (m_phase[i] + 1) % SLOTS;
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                int          r;
                bit          lit;
                logic [15:0] e_row;
                r   = m_act[i] ? (m_phase[i] / DIV) % 16 : 0;
                lit = m_act[i] && (m_phase[i] % DIV) >= BLANK;
                e_row = lit ? (16'd1 << r) : 16'd0;
                chk("row_bin", i, 16'(rb[i]), 16'(r));
                chk("pat_idx", i, 16'(pi[i]), 16'(m_pat[i]));
                chk("row", i, row_o[i], e_row);
                chk("col", i, col_o[i], lit ? m_col[i] : 16'd0);
                chk("frame_done", i, 16'(fd[i]), 16'(m_fd[i]));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_lit_row(input logic [3:0] r);
        int cnt;
        cnt = 0;
        while (!(rb[0] == r && row_o[0] != 16'd0) && cnt < 300) begin
            tick(1);
            cnt++;
        end
        if (cnt >= 300) timeout_fail("wait_lit_row");
    endtask

    task automatic wait_fd();
        int cnt;
        cnt = 0;
        tick(1);
        while (fd[0] !== 1'b1 && cnt < 300) begin
            tick(1);
            cnt++;
        end
        if (cnt >= 300) timeout_fail("wait_frame_done");
    endtask

    initial begin
        int cnt;
        int prev;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0; en = 1'b1; auto_mode = 1'b0; pat_sel_in = 2'd3; col_xor = '0;

        // Reset held with en=1: everything stays dark.
        for (int k = 0; k < 3; k++) begin
            tick(1);
            chk("rst_row", 0, row_o[0], 16'h0000);
            chk("rst_col", 0, col_o[0], 16'h0000);
            chk("rst_row_bin", 0, 16'(rb[0]), 16'h0);
            chk("rst_pat_idx", 0, 16'(pi[0]), 16'h0);
            chk("rst_frame_done", 0, 16'(fd[0]), 16'h0);
        end
        rst_n = 1'b1; en = 1'b0; pat_sel_in = 2'd0;
        tick(2);
        chk("idle_row", 0, row_o[0], 16'h0000);

        // First row: two blank cycles, six lit cycles, then row 1 blanked.
        en = 1'b1;
        tick(1);
        chk("blank0_row", 0, row_o[0], 16'h0000);
        tick(1);
        chk("blank1_row", 0, row_o[0], 16'h0000);
        tick(1);
        chk("show_row", 0, row_o[0], 16'h0001);
        chk("show_col", 0, col_o[0], 16'h0FF0);
        tick(5);
        chk("show_end_row", 0, row_o[0], 16'h0001);
        chk("show_end_col", 0, col_o[0], 16'h0FF0);
        tick(1);
        chk("next_row_bin", 0, 16'(rb[0]), 16'h1);
        chk("next_row", 0, row_o[0], 16'h0000);

        // Three frames free-running: exactly three frame pulses.
        cnt = 0;
        for (int k = 0; k < 3 * SLOTS; k++) begin
            tick(1);
            if (fd[0]) cnt++;
        end
        chk("fd_count", 0, 16'(cnt), 16'd3);

        // Column word is latched: changing the ROM output mid-row has no effect.
        wait_lit_row(4'd4);
        col_xor = 16'hA5A5;
        tick(2);
        chk("col_latched", 0, col_o[0], rom(2'd0, 4'd4));
        wait_lit_row(4'd6);
        chk("col_new_word", 0, col_o[0], rom(2'd0, 4'd6) ^ 16'hA5A5);
        col_xor = '0;

        // Auto rotation: one step every 2 frames (256 cycles), wrapping 3 -> 0.
        auto_mode = 1'b1;
        prev = 0;
        for (int k = 1; k <= 4; k++) begin
            cnt = 0;
            while (pi[0] == 2'(prev) && cnt < 300) begin
                tick(1);
                cnt++;
            end
            if (cnt >= 300) timeout_fail("auto_step");
            else begin
                chk("auto_step", 0, 16'(pi[0]), 16'(k % 4));
                if (k > 1) chk("auto_period", 0, 16'(cnt), 16'd256);
            end
            prev = k % 4;
        end
        chk("auto_wrap_np3", 1, 16'(pi[1]), 16'd1);

        // Manual select changes only at the frame boundary.
        auto_mode = 1'b0;
        wait_lit_row(4'd7);
        chk("manual_before", 0, 16'(pi[0]), 16'd0);
        pat_sel_in = 2'd2;
        tick(8);
        chk("manual_midframe", 0, 16'(pi[0]), 16'd0);
        wait_fd();
        chk("manual_after", 0, 16'(pi[0]), 16'd2);
        chk("manual_after", 1, 16'(pi[1]), 16'd2);
        pat_sel_in = 2'd1;
        wait_fd();
        chk("manual_sel1", 1, 16'(pi[1]), 16'd1);
        pat_sel_in = 2'd3;
        wait_fd();
        chk("manual_sel3", 0, 16'(pi[0]), 16'd3);
        chk("sel_out_of_range_hold", 1, 16'(pi[1]), 16'd1);

        // Dropping en during SHOW of row 9.
        wait_lit_row(4'd9);
        en = 1'b0;
        tick(1);
        chk("en_off_row", 0, row_o[0], 16'h0000);
        chk("en_off_col", 0, col_o[0], 16'h0000);
        chk("en_off_row_bin", 0, 16'(rb[0]), 16'h0);
        chk("en_off_frame_done", 0, 16'(fd[0]), 16'h0);
        chk("en_off_pat_kept", 0, 16'(pi[0]), 16'd3);
        tick(3);
        en = 1'b1;
        tick(1);
        chk("restart_blank0", 0, row_o[0], 16'h0000);
        tick(1);
        chk("restart_blank1", 0, row_o[0], 16'h0000);
        tick(1);
        chk("restart_row", 0, row_o[0], 16'h0001);
        chk("restart_col", 0, col_o[0], rom(2'd3, 4'd0));

        // One-cycle reset during SHOW of row 9.
        wait_lit_row(4'd9);
        rst_n = 1'b0;
        tick(1);
        chk("midrst_row", 0, row_o[0], 16'h0000);
        chk("midrst_col", 0, col_o[0], 16'h0000);
        chk("midrst_row_bin", 0, 16'(rb[0]), 16'h0);
        chk("midrst_pat_idx", 0, 16'(pi[0]), 16'h0);
        chk("midrst_pat_idx", 1, 16'(pi[1]), 16'h0);
        chk("midrst_frame_done", 0, 16'(fd[0]), 16'h0);
        rst_n = 1'b1;
        tick(3);
        chk("postrst_row", 0, row_o[0], 16'h0001);
        chk("postrst_col", 0, col_o[0], 16'h0FF0);
        tick(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
